// File: rtl/seg_mux_n.sv
// N-digit time-multiplexed seven-segment driver with anti-ghost blanking and a
// frame-synchronous double buffer. Define SEG_MUX_BRIGHTNESS_EN for the PWM brightness gate.
module seg_mux_n #(
  parameter int unsigned CLK_IN         = 80_000_000,
  parameter int unsigned DIGIT_FREQ     = 1_000,
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned BLANK_CYCLES   = 80,
  parameter bit          COMMON_ANODE   = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7*DIGITS-1:0]   seg_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic [3:0]            brightness,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_start,
  output logic                  upd_pending
);

  localparam int unsigned DWELL = CLK_IN / DIGIT_FREQ;
  localparam int unsigned CNT_W = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam int unsigned IDX_W = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF   = {7{COMMON_ANODE}};
  localparam logic              DP_OFF    = COMMON_ANODE;
  localparam logic [DIGITS-1:0] SEL_OFF   = {DIGITS{SEL_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] SEL_ONE   = DIGITS'(1);

  // Every slot needs at least one active cycle after its blanking window.
  if (DIGITS < 2 || DWELL <= BLANK_CYCLES) begin : g_param_check
    $error("seg_mux_n: DIGITS must be >= 2 and DWELL must exceed BLANK_CYCLES");
  end

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [DIGITS-1:0][6:0]      disp_seg_q, disp_seg_d, pend_seg_q, pend_seg_d;
  logic [DIGITS-1:0]           disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic                        pending_q, pending_d;
  logic [6:0]                  seg_q, seg_d;
  logic                        dp_q, dp_d;
  logic [DIGITS-1:0]           sel_q, sel_d;
  logic                        fs_q, fs_d;
  logic                        upd_q, upd_d;
  logic                        wrap_c, boundary_c, active_c, gate_c, lit_c;

  assign wrap_c     = (cnt_q == CNT_LAST);
  assign boundary_c = wrap_c && (idx_q == IDX_LAST);
  assign active_c   = (cnt_q >= CNT_BLANK);
  assign lit_c      = active_c && gate_c;

`ifdef SEG_MUX_BRIGHTNESS_EN
  // pwm restarts at the first active cycle so every slot sees the same duty pattern.
  logic [3:0] pwm_q, pwm_d, pwm_cur_c;
  assign pwm_cur_c = (cnt_q == CNT_BLANK) ? 4'd0 : pwm_q;
  assign gate_c    = (pwm_cur_c <= brightness);
  assign pwm_d     = active_c ? (pwm_cur_c + 4'd1) : pwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= 4'd0;
    else        pwm_q <= pwm_d;
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign gate_c            = 1'b1;
`endif

  // Slot sequencing, double buffer and output next-state.
  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    disp_seg_d = disp_seg_q;
    disp_dp_d  = disp_dp_q;
    pend_seg_d = pend_seg_q;
    pend_dp_d  = pend_dp_q;
    pending_d  = pending_q;

    if (wrap_c) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Swap first, then capture, so a boundary-cycle load lands in pending.
    if (boundary_c && pending_q) begin
      disp_seg_d = pend_seg_q;
      disp_dp_d  = pend_dp_q;
      pending_d  = 1'b0;
    end
    if (load) begin
      pend_seg_d = seg_in;
      pend_dp_d  = dp_in;
      pending_d  = 1'b1;
    end

    seg_d = (lit_c ? disp_seg_q[idx_q] : 7'h00) ^ SEG_OFF;
    dp_d  = (lit_c & disp_dp_q[idx_q]) ^ DP_OFF;
    sel_d = (lit_c ? (SEL_ONE << idx_q) : '0) ^ SEL_OFF;
    fs_d  = (cnt_q == '0) && (idx_q == '0);
    upd_d = pending_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_seg_q <= '0;
      disp_dp_q  <= '0;
      pend_seg_q <= '0;
      pend_dp_q  <= '0;
      pending_q  <= 1'b0;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
      sel_q      <= SEL_OFF;
      fs_q       <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_seg_q <= disp_seg_d;
      disp_dp_q  <= disp_dp_d;
      pend_seg_q <= pend_seg_d;
      pend_dp_q  <= pend_dp_d;
      pending_q  <= pending_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      sel_q      <= sel_d;
      fs_q       <= fs_d;
      upd_q      <= upd_d;
    end
  end

  assign seg_out     = seg_q;
  assign dp_out      = dp_q;
  assign dig_sel     = sel_q;
  assign frame_start = fs_q;
  assign upd_pending = upd_q;

endmodule

// File: tb/tb_seg_mux_n.sv
// Self-checking bench for seg_mux_n: directed steps plus random loads/brightness,
// compared every cycle against a frame-arithmetic reference model.
module tb_seg_mux_n;

  localparam int unsigned CLK_IN         = 1000;
  localparam int unsigned DIGIT_FREQ     = 100;
  localparam int unsigned DIGITS         = 4;
  localparam int unsigned BLANK_CYCLES   = 2;
  localparam bit          COMMON_ANODE   = 1'b1;
  localparam bit          SEL_ACTIVE_LOW = 1'b0;
  localparam int          DWELL          = CLK_IN / DIGIT_FREQ;
  localparam int          FRAME          = DIGITS * DWELL;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [7*DIGITS-1:0]  seg_in;
  logic [DIGITS-1:0]    dp_in;
  logic                 load;
  logic [3:0]           brightness;
  logic [6:0]           seg_out;
  logic                 dp_out;
  logic [DIGITS-1:0]    dig_sel;
  logic                 frame_start;
  logic                 upd_pending;

  always #5 clk = ~clk;

  seg_mux_n #(
    .CLK_IN(CLK_IN), .DIGIT_FREQ(DIGIT_FREQ), .DIGITS(DIGITS),
    .BLANK_CYCLES(BLANK_CYCLES), .COMMON_ANODE(COMMON_ANODE), .SEL_ACTIVE_LOW(SEL_ACTIVE_LOW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dp_in(dp_in), .load(load),
    .brightness(brightness), .seg_out(seg_out), .dp_out(dp_out), .dig_sel(dig_sel),
    .frame_start(frame_start), .upd_pending(upd_pending)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: k counts clock edges since reset release.
  int         k = 0;
  logic [6:0] m_disp [DIGITS];
  logic [6:0] m_pend [DIGITS];
  bit         m_ddp  [DIGITS];
  bit         m_pdp  [DIGITS];
  bit         m_flag = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t k=%0d)", tag, obs, exp, $time, k);
    end
  endtask

  task automatic model_reset();
    k      = 0;
    m_flag = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      m_disp[d] = 7'h00;
      m_pend[d] = 7'h00;
      m_ddp[d]  = 1'b0;
      m_pdp[d]  = 1'b0;
    end
  endtask

  task automatic step();
    logic [6:0]        e_seg;
    logic              e_dp;
    logic [DIGITS-1:0] e_sel;
    logic              e_fs, e_upd;
    int                cnt, idx, pos;
    bit                lit;
    @(posedge clk);
    if (!rst_n) begin
      e_seg = COMMON_ANODE ? 7'h7F : 7'h00;
      e_dp  = COMMON_ANODE;
      e_sel = SEL_ACTIVE_LOW ? '1 : '0;
      e_fs  = 1'b0;
      e_upd = 1'b0;
    end else begin
      pos = k % FRAME;
      cnt = k % DWELL;
      idx = (k / DWELL) % DIGITS;
      lit = (cnt >= int'(BLANK_CYCLES));
`ifdef SEG_MUX_BRIGHTNESS_EN
      if (lit) lit = (((cnt - int'(BLANK_CYCLES)) % 16) <= int'(brightness));
`endif
      e_seg = lit ? m_disp[idx] : 7'h00;
      if (COMMON_ANODE) e_seg = ~e_seg;
      e_dp  = (lit && m_ddp[idx]) ^ COMMON_ANODE;
      e_sel = lit ? DIGITS'(1 << idx) : '0;
      if (SEL_ACTIVE_LOW) e_sel = ~e_sel;
      e_fs  = (pos == 0);
      e_upd = m_flag;
      if (pos == FRAME - 1 && m_flag) begin
        for (int d = 0; d < DIGITS; d++) begin
          m_disp[d] = m_pend[d];
          m_ddp[d]  = m_pdp[d];
        end
        m_flag = 1'b0;
      end
      if (load) begin
        for (int d = 0; d < DIGITS; d++) begin
          m_pend[d] = seg_in[7*d +: 7];
          m_pdp[d]  = dp_in[d];
        end
        m_flag = 1'b1;
      end
      k++;
    end
    #1;
    chk("seg_out", 32'(seg_out), 32'(e_seg));
    chk("dp_out", 32'(dp_out), 32'(e_dp));
    chk("dig_sel", 32'(dig_sel), 32'(e_sel));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("upd_pending", 32'(upd_pending), 32'(e_upd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the next edge will clock frame position pos.
  task automatic run_to(input int pos);
    for (int i = 0; i < FRAME && (k % FRAME) != pos; i++) step();
  endtask

  task automatic do_load(input logic [7*DIGITS-1:0] s, input logic [DIGITS-1:0] d);
    seg_in = s;
    dp_in  = d;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b1;
    load       = 1'b0;
    seg_in     = '0;
    dp_in      = '0;
    brightness = 4'd15;
    model_reset();
    #1 rst_n = 1'b0;

    // Outputs held off during reset.
    run(3);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    run(FRAME + 5);

    // Known pattern: 4 3 2 1 with digit 0's decimal point lit.
    do_load({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0001);
    run(2 * FRAME);

    // Random loads and live brightness changes.
    for (int i = 0; i < 400; i++) begin
      load   = ($urandom_range(0, 15) == 0);
      seg_in = 28'($urandom);
      dp_in  = 4'($urandom);
      if ($urandom_range(0, 7) == 0) brightness = 4'($urandom);
      step();
    end
    load = 1'b0;

    // Load A mid-frame, then B in the boundary cycle.
    brightness = 4'd15;
    run_to(15);
    do_load(28'($urandom), 4'($urandom));
    run_to(FRAME - 1);
    do_load(28'($urandom), 4'($urandom));
    run(2 * FRAME + 2);

    // Reduced brightness levels.
    brightness = 4'd3;
    run(FRAME);
    brightness = 4'd0;
    run(FRAME);
    brightness = 4'd15;

    // Reset while an update is pending discards it.
    run_to(10);
    do_load(28'($urandom) | 28'h1, 4'hF);
    run(7);
    rst_n = 1'b0;
    #1;
    chk("async_seg_off", 32'(seg_out), 32'h7F);
    chk("async_dp_off", 32'(dp_out), 32'h1);
    chk("async_sel_off", 32'(dig_sel), 32'h0);
    chk("async_upd_clr", 32'(upd_pending), 32'h0);
    run(2);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    run(2 * FRAME + 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
